autoconfig_host: RTL

Zorro II AutoConfig initiator that walks the configuration chain at $E80000. For each board it reads the identification nibbles, allocates a naturally aligned base address from either the Zorro II RAM pool ($200000–$9FFFFF) or the I/O pool ($E90000–$EFFFFF), then writes the base, or issues shut-up if the board does not fit. It sits between a start/status control port and a nibble-wide bus-cycle engine, which performs the actual Zorro II cycles, and reports one record per board.

---
 rtl/autoconfig_host.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/autoconfig_host.sv
// Zorro II AutoConfig initiator: walks the chain at $E80000, reads each board's ID nibbles,
// allocates an aligned base from the RAM or I/O pool and writes it, or shuts the board up.
module autoconfig_host #(
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned MAX_BOARDS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  board_count,
    output logic        bus_req,
    output logic        bus_rw,
    output logic [22:0] bus_addr,
    output logic [3:0]  bus_wdata,
    input  logic        bus_ack,
    input  logic [3:0]  bus_rdata,
    output logic        cfg_valid,
    output logic [7:0]  cfg_base,
    output logic [2:0]  cfg_size,
    output logic [7:0]  cfg_prodid,
    output logic [15:0] cfg_mfg,
    output logic        cfg_memspace,
    output logic        cfg_shutup
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, RD_REQ, RD_WAIT, EVAL, WR_LO, WR_HI, WR_SHUT, REPORT, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [39:0]   data_q, data_d;
    logic [7:0]    ram_ptr_q, ram_ptr_d, io_ptr_q, io_ptr_d, base_q, base_d;
    logic          shut_q, shut_d;
    logic          busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [3:0]    count_q, count_d;
    logic          req_q, req_d, rw_q, rw_d;
    logic [22:0]   addr_q, addr_d;
    logic [3:0]    wdata_q, wdata_d;
    logic          cfg_valid_q, cfg_valid_d, cfg_mem_q, cfg_mem_d, cfg_shut_q, cfg_shut_d;
    logic [7:0]    cfg_base_q, cfg_base_d, cfg_prodid_q, cfg_prodid_d;
    logic [2:0]    cfg_size_q, cfg_size_d;
    logic [15:0]   cfg_mfg_q, cfg_mfg_d;

    logic [2:0] size_code;
    logic [8:0] units, ptr9, limit9, base9, next_ptr9;
    logic       mem_sel, fits, type_ok, expired;
    logic [7:0] rd_off;
    logic [3:0] nib;
    logic       unused_bits;

    // Captured nibbles shift in high-first: [39:32] er_Type, [31:24] prodid, [23:16] er_Flags, [15:0] mfg
    always_comb begin
        size_code = data_q[34:32];
        mem_sel   = data_q[23];
        type_ok   = (data_q[39:38] == 2'b11);
        units     = (size_code == 3'd0) ? 9'd128 : (9'd1 << (size_code - 3'd1));
        ptr9      = {1'b0, (mem_sel ? ram_ptr_q : io_ptr_q)};
        limit9    = mem_sel ? 9'h0A0 : 9'h0F0;
        base9     = (ptr9 + units - 9'd1) & ~(units - 9'd1);
        next_ptr9 = base9 + units;
        fits      = (next_ptr9 <= limit9);
        rd_off    = (idx_q < 4'd6) ? {4'h0, idx_q} : ({4'h0, idx_q} + 8'd2);
        nib       = (idx_q < 4'd2) ? bus_rdata : ~bus_rdata;
        expired   = (cnt_q == CW'(TIMEOUT - 1));
    end

    assign unused_bits = ^{data_q[37:35], data_q[22:16], next_ptr9[8]};

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        ram_ptr_d    = ram_ptr_q;
        io_ptr_d     = io_ptr_q;
        base_d       = base_q;
        shut_d       = shut_q;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;
        count_d      = count_q;
        req_d        = req_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cfg_valid_d  = 1'b0;
        cfg_base_d   = cfg_base_q;
        cfg_size_d   = cfg_size_q;
        cfg_prodid_d = cfg_prodid_q;
        cfg_mfg_d    = cfg_mfg_q;
        cfg_mem_d    = cfg_mem_q;
        cfg_shut_d   = cfg_shut_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    ram_ptr_d = 8'h20;
                    io_ptr_d  = 8'hE9;
                    count_d   = '0;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    busy_d    = 1'b1;
                    idx_d     = '0;
                    state_d   = RD_REQ;
                end
            end
            RD_REQ: begin
                req_d   = 1'b1;
                rw_d    = 1'b1;
                addr_d  = {8'hE8, 7'h00, rd_off};
                cnt_d   = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus_ack) begin
                    req_d  = 1'b0;
                    data_d = {data_q[35:0], nib};
                    if (idx_q == 4'd9) begin
                        state_d = EVAL;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = RD_REQ;
                    end
                end else if (expired) begin
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EVAL: begin
                if (!type_ok) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (fits) begin
                    base_d  = base9[7:0];
                    shut_d  = 1'b0;
                    if (mem_sel) ram_ptr_d = next_ptr9[7:0];
                    else         io_ptr_d  = next_ptr9[7:0];
                    state_d = WR_LO;
                end else begin
                    base_d  = '0;
                    shut_d  = 1'b1;
                    state_d = WR_SHUT;
                end
            end
            WR_LO, WR_HI, WR_SHUT: begin
                // First cycle in each write state raises the request; later cycles await ack/timeout
                if (!req_q) begin
                    req_d = 1'b1;
                    rw_d  = 1'b0;
                    cnt_d = '0;
                    case (state_q)
                        WR_LO: begin
                            addr_d  = {8'hE8, 7'h00, 8'h25};
                            wdata_d = base_q[3:0];
                        end
                        WR_HI: begin
                            addr_d  = {8'hE8, 7'h00, 8'h24};
                            wdata_d = base_q[7:4];
                        end
                        default: begin
                            addr_d  = {8'hE8, 7'h00, 8'h26};
                            wdata_d = 4'h0;
                        end
                    endcase
                end else if (bus_ack) begin
                    req_d = 1'b0;
                    if (state_q == WR_LO) begin
                        state_d = WR_HI;
                    end else begin
                        cfg_valid_d  = 1'b1;
                        cfg_base_d   = base_q;
                        cfg_size_d   = data_q[34:32];
                        cfg_prodid_d = data_q[31:24];
                        cfg_mfg_d    = data_q[15:0];
                        cfg_mem_d    = data_q[23];
                        cfg_shut_d   = shut_q;
                        count_d      = count_q + 4'd1;
                        state_d      = REPORT;
                    end
                end else if (expired) begin
                    req_d   = 1'b0;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REPORT: begin
                if (32'(count_q) >= MAX_BOARDS) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = '0;
                    state_d = RD_REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            ram_ptr_q    <= 8'h20;
            io_ptr_q     <= 8'hE9;
            base_q       <= '0;
            shut_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            count_q      <= '0;
            req_q        <= 1'b0;
            rw_q         <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            cfg_valid_q  <= 1'b0;
            cfg_base_q   <= '0;
            cfg_size_q   <= '0;
            cfg_prodid_q <= '0;
            cfg_mfg_q    <= '0;
            cfg_mem_q    <= 1'b0;
            cfg_shut_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            ram_ptr_q    <= ram_ptr_d;
            io_ptr_q     <= io_ptr_d;
            base_q       <= base_d;
            shut_q       <= shut_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            count_q      <= count_d;
            req_q        <= req_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cfg_valid_q  <= cfg_valid_d;
            cfg_base_q   <= cfg_base_d;
            cfg_size_q   <= cfg_size_d;
            cfg_prodid_q <= cfg_prodid_d;
            cfg_mfg_q    <= cfg_mfg_d;
            cfg_mem_q    <= cfg_mem_d;
            cfg_shut_q   <= cfg_shut_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign board_count  = count_q;
    assign bus_req      = req_q;
    assign bus_rw       = rw_q;
    assign bus_addr     = addr_q;
    assign bus_wdata    = wdata_q;
    assign cfg_valid    = cfg_valid_q;
    assign cfg_base     = cfg_base_q;
    assign cfg_size     = cfg_size_q;
    assign cfg_prodid   = cfg_prodid_q;
    assign cfg_mfg      = cfg_mfg_q;
    assign cfg_memspace = cfg_mem_q;
    assign cfg_shutup   = cfg_shut_q;

endmodule
